// File: rtl/matrix_pkg.sv
// Shared types and helpers for the streaming matrix multiplier bridge.
package matrix_pkg;

    // Bridge sequencing: load A, load B, capture product, drain C.
    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CAPTURE,
        DRAIN
    } state_t;

    // Width of one product element: a DW x DW product summed over N terms.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/mat_elem_counter.sv
// Modulo-(N*N) element index shared by the load and drain phases.
module mat_elem_counter #(
    parameter  int N  = 3,
    localparam int IW = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [IW-1:0] idx,
    output logic          at_last
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);

    assign at_last = (idx == LAST_IDX);

    // Advance on each accepted element, wrapping to 0 after the final one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            idx <= at_last ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/matrix_stream_bridge.sv
// Deserialises A and B from an element stream into flat buses for the
// combinational multiplier, captures the product and streams C row-major.
module matrix_stream_bridge
    import matrix_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int DW = 8,
    localparam int AW = acc_width(N, DW)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_data,
    input  logic              s_last,
    output logic [N*N*DW-1:0] a_flat,
    output logic [N*N*DW-1:0] b_flat,
    input  logic [N*N*AW-1:0] c_flat,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [AW-1:0]     m_data,
    output logic              m_last,
    output logic              busy,
    output logic              frame_err
);

    localparam int IW = $clog2(N * N);

    state_t            state;
    state_t            state_nxt;
    logic [IW-1:0]     idx;
    logic              at_last;
    logic              s_hs;
    logic              m_hs;
    logic              cnt_clr;
    logic              exp_last;
    logic [N*N*AW-1:0] c_reg;

    assign s_hs     = s_valid & s_ready;
    assign m_hs     = m_valid & m_ready;
    assign cnt_clr  = (state == IDLE) || (state == CAPTURE);
    assign exp_last = (state == LOAD_B) && at_last;

    mat_elem_counter #(.N(N)) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (s_hs | m_hs),
        .clr     (cnt_clr),
        .idx     (idx),
        .at_last (at_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode; outputs depend only on registered state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                state_nxt = LOAD_A;
            end
            LOAD_A: begin
                s_ready = 1'b1;
                if (s_valid && at_last) state_nxt = LOAD_B;
            end
            LOAD_B: begin
                s_ready = 1'b1;
                if (s_valid && at_last) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt = DRAIN;
            end
            DRAIN: begin
                m_valid = 1'b1;
                if (m_ready && at_last) state_nxt = LOAD_A;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Element writes into A/B and product capture; values persist until overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these wide registers are reset because partial frames must not leak after an abort.
            a_flat <= '0;
            b_flat <= '0;
            c_reg  <= '0;
        end else begin
            if (s_hs && state == LOAD_A) a_flat[int'(idx)*DW +: DW] <= s_data;
            if (s_hs && state == LOAD_B) b_flat[int'(idx)*DW +: DW] <= s_data;
            if (state == CAPTURE)        c_reg <= c_flat;
        end
    end

    // One-cycle framing pulse when s_last disagrees with the element position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= s_hs && (s_last != exp_last);
        end
    end

    // Output element select; idx only moves on a handshake, so data holds under stall.
    always_comb begin
        m_data = '0;
        m_last = 1'b0;
        if (state == DRAIN) begin
            m_data = c_reg[int'(idx)*AW +: AW];
            m_last = at_last;
        end
    end

endmodule
